// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: condition-code register, JZ/JN/JC/JV/LOOP
// resolution, registered PC redirect and multi-cycle flush. Optional macro BU_STATS_EN.
module branch_resolve_unit #(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [2:0]        bu_op,
  input  logic              flags_we,
  input  logic [3:0]        alu_flags,
  input  logic [DATA_W-1:0] rb_val,
  input  logic [DATA_W-1:0] target,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              loop_we,
  output logic [DATA_W-1:0] loop_wdata,
  output logic [3:0]        ccr,
  output logic              busy
`ifdef BU_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       nt_cnt
`endif
);

  localparam logic [2:0] OP_JZ   = 3'b001;
  localparam logic [2:0] OP_JN   = 3'b010;
  localparam logic [2:0] OP_JC   = 3'b011;
  localparam logic [2:0] OP_JV   = 3'b100;
  localparam logic [2:0] OP_LOOP = 3'b101;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [3:0]        eff_flags;
  logic [DATA_W-1:0] loop_d;
  logic              cond_taken;
  logic              is_branch;
  logic              accept;
  logic              take;

  // Same-cycle ALU flags win over the stored CCR so back-to-back compare/branch works.
  assign eff_flags = flags_we ? alu_flags : ccr;
  assign loop_d    = rb_val - DATA_W'(1);
  assign accept    = valid_i && !stall_i && (state == IDLE);
  assign take      = accept && cond_taken;

  always_comb begin
    cond_taken = 1'b0;
    is_branch  = 1'b1;
    case (bu_op)
      OP_JZ:   cond_taken = eff_flags[3];
      OP_JN:   cond_taken = eff_flags[2];
      OP_JC:   cond_taken = eff_flags[1];
      OP_JV:   cond_taken = eff_flags[0];
      OP_LOOP: cond_taken = (loop_d != '0);
      default: is_branch  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ccr        <= '0;
      pc_src     <= 1'b0;
      pc_target  <= '0;
      flush      <= 1'b0;
      busy       <= 1'b0;
      loop_we    <= 1'b0;
      loop_wdata <= '0;
    end else if (!stall_i) begin
      if (flags_we)
        ccr <= alu_flags;
      loop_we <= accept && (bu_op == OP_LOOP);
      if (accept && (bu_op == OP_LOOP))
        loop_wdata <= loop_d;
      pc_src <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state     <= REDIRECT;
            pc_src    <= 1'b1;
            pc_target <= target;
            flush     <= 1'b1;
            busy      <= 1'b1;
            cnt       <= CNT_INIT;
          end
        end
        REDIRECT: begin
          if (cnt != 3'd0) begin
            state <= FLUSH;
            cnt   <= cnt - 3'd1;
          end else begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt == 3'd0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BU_STATS_EN
  // Saturating counters; reserved/none opcodes are not branches and are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
      nt_cnt    <= '0;
    end else if (accept && is_branch) begin
      if (cond_taken) begin
        if (taken_cnt != 16'hFFFF)
          taken_cnt <= taken_cnt + 16'd1;
      end else if (nt_cnt != 16'hFFFF) begin
        nt_cnt <= nt_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus hand-written
// flush/stall/reset sequences; stats section compiled when BU_STATS_EN is defined.
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_i;
  logic       valid_i;
  logic [2:0] bu_op;
  logic       flags_we;
  logic [3:0] alu_flags;
  logic [7:0] rb_val;
  logic [7:0] target;
  logic       pc_src;
  logic [7:0] pc_target;
  logic       flush;
  logic       loop_we;
  logic [7:0] loop_wdata;
  logic [3:0] ccr;
  logic       busy;
`ifdef BU_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(8), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .valid_i(valid_i),
    .bu_op(bu_op), .flags_we(flags_we), .alu_flags(alu_flags),
    .rb_val(rb_val), .target(target), .pc_src(pc_src), .pc_target(pc_target),
    .flush(flush), .loop_we(loop_we), .loop_wdata(loop_wdata), .ccr(ccr),
    .busy(busy)
`ifdef BU_STATS_EN
    , .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] pre;
    logic       byp_we;
    logic [3:0] byp;
    logic [2:0] op;
    logic [7:0] rb;
    logic [7:0] tgt;
    logic       exp_taken;
    logic       exp_lwe;
    logic [7:0] exp_wdata;
    logic [3:0] exp_ccr;
  } vec_t;

  vec_t vecs[14];

  // Outputs are sampled 1 time unit after the rising edge, before inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i   = 1'b0;
    bu_op     = 3'b000;
    flags_we  = 1'b0;
    alu_flags = 4'b0000;
    stall_i   = 1'b0;
    rb_val    = 8'h00;
    target    = 8'h00;
  endtask

  task automatic applyStimulus(input vec_t v);
    flags_we  = 1'b1;
    alu_flags = v.pre;
    tick();
    valid_i   = 1'b1;
    bu_op     = v.op;
    rb_val    = v.rb;
    target    = v.tgt;
    flags_we  = v.byp_we;
    alu_flags = v.byp;
    tick();
    checkOutput({v.name, " pc_src"}, 16'(pc_src), 16'(v.exp_taken));
    if (v.exp_taken)
      checkOutput({v.name, " pc_target"}, 16'(pc_target), 16'(v.tgt));
    checkOutput({v.name, " flush1"}, 16'(flush), 16'(v.exp_taken));
    checkOutput({v.name, " busy1"}, 16'(busy), 16'(v.exp_taken));
    checkOutput({v.name, " loop_we"}, 16'(loop_we), 16'(v.exp_lwe));
    if (v.exp_lwe)
      checkOutput({v.name, " loop_wdata"}, 16'(loop_wdata), 16'(v.exp_wdata));
    checkOutput({v.name, " ccr"}, 16'(ccr), 16'(v.exp_ccr));
    idle_inputs();
    tick();
    checkOutput({v.name, " pc_src2"}, 16'(pc_src), 16'd0);
    checkOutput({v.name, " flush2"}, 16'(flush), 16'(v.exp_taken));
    checkOutput({v.name, " loop_we2"}, 16'(loop_we), 16'd0);
    tick();
    checkOutput({v.name, " flush3"}, 16'(flush), 16'd0);
    checkOutput({v.name, " busy3"}, 16'(busy), 16'd0);
  endtask

`ifdef BU_STATS_EN
  task automatic run_branch(input logic [2:0] op, input logic [3:0] f, input logic [7:0] rb);
    valid_i   = 1'b1;
    bu_op     = op;
    flags_we  = 1'b1;
    alu_flags = f;
    rb_val    = rb;
    target    = 8'hA0;
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask
`endif

  initial begin
    int n_pc;
    int n_fl;

    //            name      pre     bwe   byp     op      rb     tgt    tk    lwe   wdata  ccr
    vecs[0]  = '{"jz_t",   4'b1000, 1'b0, 4'b0000, 3'b001, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h00, 4'b1000};
    vecs[1]  = '{"jn_byp", 4'b0000, 1'b1, 4'b0100, 3'b010, 8'h00, 8'h55, 1'b1, 1'b0, 8'h00, 4'b0100};
    vecs[2]  = '{"jn_bnt", 4'b0000, 1'b1, 4'b1011, 3'b010, 8'h00, 8'h56, 1'b0, 1'b0, 8'h00, 4'b1011};
    vecs[3]  = '{"jn_ovr", 4'b0100, 1'b1, 4'b0000, 3'b010, 8'h00, 8'h57, 1'b0, 1'b0, 8'h00, 4'b0000};
    vecs[4]  = '{"jc_t",   4'b0010, 1'b0, 4'b0000, 3'b011, 8'h00, 8'h10, 1'b1, 1'b0, 8'h00, 4'b0010};
    vecs[5]  = '{"jv_t",   4'b0001, 1'b0, 4'b0000, 3'b100, 8'h00, 8'h20, 1'b1, 1'b0, 8'h00, 4'b0001};
    vecs[6]  = '{"jv_nt",  4'b1110, 1'b0, 4'b0000, 3'b100, 8'h00, 8'h21, 1'b0, 1'b0, 8'h00, 4'b1110};
    vecs[7]  = '{"loop3",  4'b0000, 1'b0, 4'b0000, 3'b101, 8'h03, 8'h40, 1'b1, 1'b1, 8'h02, 4'b0000};
    vecs[8]  = '{"loop1",  4'b0000, 1'b0, 4'b0000, 3'b101, 8'h01, 8'h44, 1'b0, 1'b1, 8'h00, 4'b0000};
    vecs[9]  = '{"loop0",  4'b0000, 1'b0, 4'b0000, 3'b101, 8'h00, 8'h41, 1'b1, 1'b1, 8'hFF, 4'b0000};
    vecs[10] = '{"op000",  4'b1111, 1'b0, 4'b0000, 3'b000, 8'h05, 8'h60, 1'b0, 1'b0, 8'h00, 4'b1111};
    vecs[11] = '{"op110",  4'b1111, 1'b0, 4'b0000, 3'b110, 8'h05, 8'h61, 1'b0, 1'b0, 8'h00, 4'b1111};
    vecs[12] = '{"op111",  4'b1111, 1'b0, 4'b0000, 3'b111, 8'h05, 8'h62, 1'b0, 1'b0, 8'h00, 4'b1111};
    vecs[13] = '{"jz_nt",  4'b0111, 1'b0, 4'b0000, 3'b001, 8'h00, 8'h63, 1'b0, 1'b0, 8'h00, 4'b0111};

    idle_inputs();
    rst_n = 1'b0;
    #23;
    checkOutput("rst pc_src", 16'(pc_src), 16'd0);
    checkOutput("rst flush", 16'(flush), 16'd0);
    checkOutput("rst busy", 16'(busy), 16'd0);
    checkOutput("rst ccr", 16'(ccr), 16'd0);
    checkOutput("rst loop_we", 16'(loop_we), 16'd0);
    checkOutput("rst pc_target", 16'(pc_target), 16'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i]);

    // Taken JC followed by a valid JV (V=1) presented while redirecting/flushing.
    flags_we = 1'b1; alu_flags = 4'b0010;
    tick();
    valid_i = 1'b1; bu_op = 3'b011; target = 8'h90; flags_we = 1'b0;
    n_pc = 0; n_fl = 0;
    tick();
    n_pc += int'(pc_src); n_fl += int'(flush);
    bu_op = 3'b100; target = 8'h99; flags_we = 1'b1; alu_flags = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_pc += int'(pc_src); n_fl += int'(flush);
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_pc += int'(pc_src); n_fl += int'(flush);
    end
    checkOutput("squash pc_src count", 16'(n_pc), 16'd1);
    checkOutput("squash flush width", 16'(n_fl), 16'd2);
    checkOutput("squash pc_target", 16'(pc_target), 16'h90);
    checkOutput("ccr update in flush", 16'(ccr), 16'b0001);

    // Stall for 3 cycles while in FLUSH stretches flush to 5 cycles; ccr frozen.
    flags_we = 1'b1; alu_flags = 4'b1000;
    tick();
    valid_i = 1'b1; bu_op = 3'b001; target = 8'h77; flags_we = 1'b0;
    n_fl = 0;
    tick();
    n_fl += int'(flush);
    idle_inputs();
    tick();
    n_fl += int'(flush);
    stall_i = 1'b1; flags_we = 1'b1; alu_flags = 4'b0110;
    valid_i = 1'b1; bu_op = 3'b010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_fl += int'(flush);
    end
    checkOutput("stall ccr hold", 16'(ccr), 16'b1000);
    checkOutput("stall busy", 16'(busy), 16'd1);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_fl += int'(flush);
    end
    checkOutput("stall flush width", 16'(n_fl), 16'd5);
    checkOutput("stall end busy", 16'(busy), 16'd0);

    // Asynchronous reset in the middle of a redirect.
    flags_we = 1'b1; alu_flags = 4'b0100;
    tick();
    valid_i = 1'b1; bu_op = 3'b010; target = 8'h33; flags_we = 1'b0;
    tick();
    idle_inputs();
    checkOutput("pre-rst pc_src", 16'(pc_src), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst pc_src", 16'(pc_src), 16'd0);
    checkOutput("async rst flush", 16'(flush), 16'd0);
    checkOutput("async rst busy", 16'(busy), 16'd0);
    #10;
    rst_n = 1'b1;
    tick();
    checkOutput("post-rst flush", 16'(flush), 16'd0);

`ifdef BU_STATS_EN
    run_branch(3'b001, 4'b1000, 8'h00);
    run_branch(3'b010, 4'b0100, 8'h00);
    run_branch(3'b011, 4'b0010, 8'h00);
    run_branch(3'b100, 4'b0001, 8'h00);
    run_branch(3'b101, 4'b0000, 8'h05);
    run_branch(3'b001, 4'b0000, 8'h00);
    run_branch(3'b101, 4'b0000, 8'h01);
    run_branch(3'b011, 4'b0000, 8'h00);
    run_branch(3'b110, 4'b1111, 8'h00);
    checkOutput("taken_cnt", taken_cnt, 16'd5);
    checkOutput("nt_cnt", nt_cnt, 16'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
